mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register (start, MDU control, forwarded operands).
- Its result and busy flag go to the EX/MEM register and to the ID-stage hazard unit.
- Holds the architectural HI/LO registers.
- Models multi-cycle MULT/MULTU/DIV/DIVU latency and single-cycle MFHI/MFLO/MTHI/MTLO.

---
 rtl/mdu_unit_pkg.sv | 34 +++
 rtl/mdu_arith.sv | 72 +++++++
 rtl/mdu_unit.sv | 123 ++++++++++++
 tb/tb_mdu_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Operation codes match the MDUCtrl field produced by the decoder.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == MDU_MULT) || (code == MDU_MULTU) ||
               (code == MDU_DIV)  || (code == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] code);
        return (code == MDU_DIV) || (code == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product/quotient/remainder of the latched operands.
// hold flags a divide by zero, in which case HI/LO must keep their old values.
module mdu_arith
    import mdu_unit_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hold
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] div_u;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_m;
    logic [31:0] quot_m;
    logic [31:0] rem_m;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // A zero divisor is replaced by one so the dividers never produce X; the result is discarded anyway.
    assign div_u  = (b == 32'd0) ? 32'd1 : b;
    assign quot_u = a / div_u;
    assign rem_u  = a % div_u;

    // Signed divide through magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign mag_a  = a[31] ? (32'd0 - a) : a;
    assign mag_b  = b[31] ? (32'd0 - b) : b;
    assign div_m  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign quot_m = mag_a / div_m;
    assign rem_m  = mag_a % div_m;
    assign quot_s = (a[31] ^ b[31]) ? (32'd0 - quot_m) : quot_m;
    assign rem_s  = a[31] ? (32'd0 - rem_m) : rem_m;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        hold = 1'b0;
        case (op)
            MDU_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MDU_DIV: begin
                hi   = rem_s;
                lo   = quot_s;
                hold = (b == 32'd0);
            end
            MDU_DIVU: begin
                hi   = rem_u;
                lo   = quot_u;
                hold = (b == 32'd0);
            end
            default: hold = 1'b1;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models multi-cycle MULT/DIV latency
// and single-cycle HI/LO moves; MDUResult is a combinational HI/LO read port.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        intExcReq,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    mdu_op_e            op_reg, op_next;
    logic [31:0]        a_reg, a_next;
    logic [31:0]        b_reg, b_next;

    logic [31:0]        arith_hi;
    logic [31:0]        arith_lo;
    logic               arith_hold;

    mdu_arith u_arith (
        .op   (op_reg),
        .a    (a_reg),
        .b    (b_reg),
        .hi   (arith_hi),
        .lo   (arith_lo),
        .hold (arith_hold)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            op_reg    <= MDU_NONE;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        case (state_reg)
            ST_IDLE: begin
                // A cancelled EX instruction must leave no trace, so everything hinges on intExcReq.
                if (!intExcReq) begin
                    if (start && is_muldiv(MDUCtrl)) begin
                        state_next = ST_RUN;
                        op_next    = mdu_op_e'(MDUCtrl);
                        a_next     = A;
                        b_next     = B;
                        count_next = is_div(MDUCtrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (MDUCtrl == MDU_MTHI) begin
                        hi_next = A;
                    end else if (MDUCtrl == MDU_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            ST_RUN: begin
                // Once running the operation is committed; exceptions no longer cancel it.
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    if (!arith_hold) begin
                        hi_next = arith_hi;
                        lo_next = arith_lo;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    always_comb begin
        MDUResult = 32'd0;
        if (MDUCtrl == MDU_MFHI) begin
            MDUResult = hi_reg;
        end else if (MDUCtrl == MDU_MFLO) begin
            MDUResult = lo_reg;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a transaction-level HI/LO model checked every
// negedge, plus hand-computed literal expectations for each scenario.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        intExcReq;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUResult;

    int total_checks = 0;
    int passed_checks = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MDUCtrl   (MDUCtrl),
        .A         (A),
        .B         (B),
        .intExcReq (intExcReq),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .MDUResult (MDUResult)
    );

    always #5 clk = ~clk;

    // Model: an accepted op yields its result after a fixed number of edges.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic        m_write = 1'b0;
    int          m_left = 0;

    always @(posedge clk or posedge reset) begin
        longint      sa, sb, q, r;
        logic [63:0] pu;
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_write = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_write) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (!intExcReq) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            if (start && MDUCtrl == 4'd1) begin
                q = sa * sb; p_hi = q[63:32]; p_lo = q[31:0]; m_write = 1'b1; m_left = 5;
            end else if (start && MDUCtrl == 4'd2) begin
                pu = {32'd0, A} * {32'd0, B}; p_hi = pu[63:32]; p_lo = pu[31:0]; m_write = 1'b1; m_left = 5;
            end else if (start && MDUCtrl == 4'd3) begin
                m_write = (B != 32'd0);
                if (m_write) begin
                    q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0];
                end
                m_left = 10;
            end else if (start && MDUCtrl == 4'd4) begin
                m_write = (B != 32'd0);
                if (m_write) begin
                    p_lo = A / B; p_hi = A % B;
                end
                m_left = 10;
            end else if (MDUCtrl == 4'd7) begin
                m_hi = A;
            end else if (MDUCtrl == 4'd8) begin
                m_lo = A;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        else passed_checks++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle of an MDU instruction in EX; inputs return to idle afterwards.
    task automatic do_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic exc);
        start = st; MDUCtrl = ctrl; A = a; B = b; intExcReq = exc;
        cyc();
        $display("op ctrl=%0d A=%h B=%h start=%0b exc=%0b -> busy=%0b HI=%h LO=%h",
                 ctrl, a, b, st, exc, busy, HI, LO);
        start = 1'b0; MDUCtrl = 4'd0; intExcReq = 1'b0;
    endtask

    task automatic busy_len(input string name, input int exp);
        int n = 0;
        while (busy && n < 50) begin
            n++;
            cyc();
        end
        check(name, 32'(n), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; MDUCtrl = 4'd0; A = 32'd0; B = 32'd0; intExcReq = 1'b0;
        fork
            forever begin
                @(negedge clk);
                check("cmp_busy", {31'd0, busy}, {31'd0, m_left > 0});
                check("cmp_hi", HI, m_hi);
                check("cmp_lo", LO, m_lo);
                check("cmp_result", MDUResult,
                      (MDUCtrl == 4'd5) ? m_hi : (MDUCtrl == 4'd6) ? m_lo : 32'd0);
                if ((m_left > 0) && (start || MDUCtrl == 4'd7 || MDUCtrl == 4'd8)) begin
                    total_checks++;
                    $display("FAIL protocol @%0t: MDU instruction issued while busy", $time);
                end
            end
        join_none
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        cyc(); cyc();
        reset = 1'b0;

        // 1: signed multiply
        do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        busy_len("mult_busy", 5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);
        MDUCtrl = 4'd5; #1;
        check("mfhi", MDUResult, 32'hFFFFFFFF);
        MDUCtrl = 4'd6; #1;
        check("mflo", MDUResult, 32'hFFFFFFFA);
        MDUCtrl = 4'd0;

        // 2: divides
        do_op(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        busy_len("divu_busy", 10);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        busy_len("div_busy", 10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        busy_len("div_ovf_busy", 10);
        check("div_ovf_lo", LO, 32'h80000000);
        check("div_ovf_hi", HI, 32'd0);

        // 3: divide by zero holds HI/LO
        do_op(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
        do_op(4'd8, 32'h5678, 32'd0, 1'b0, 1'b0);
        check("mthi", HI, 32'h1234);
        check("mtlo", LO, 32'h5678);
        do_op(4'd3, 32'd55, 32'd0, 1'b1, 1'b0);
        busy_len("div0_busy", 10);
        check("div0_hi", HI, 32'h1234);
        check("div0_lo", LO, 32'h5678);

        // 4: exception suppression, then exception during RUN
        do_op(4'd2, 32'd9, 32'd9, 1'b1, 1'b1);
        check("exc_start_busy", {31'd0, busy}, 32'd0);
        do_op(4'd7, 32'hAAAA, 32'd0, 1'b0, 1'b1);
        check("exc_mthi_hi", HI, 32'h1234);
        check("exc_lo", LO, 32'h5678);
        do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        cyc(); cyc();
        intExcReq = 1'b1;
        cyc();
        intExcReq = 1'b0;
        busy_len("multu_exc_busy", 2);
        check("multu_hi", HI, 32'hFFFFFFFE);
        check("multu_lo", LO, 32'h00000001);

        // 5: async reset mid-divide
        do_op(4'd4, 32'd1000, 32'd3, 1'b1, 1'b0);
        cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        cyc();
        #2 reset = 1'b0;
        do_op(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        busy_len("post_rst_busy", 10);
        check("post_rst_lo", LO, 32'd14);
        check("post_rst_hi", HI, 32'd2);

        // 6: move-to then move-from, undefined code
        do_op(4'd8, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
        MDUCtrl = 4'd6; #1;
        check("mflo_dead", MDUResult, 32'hDEADBEEF);
        check("mflo_nobusy", {31'd0, busy}, 32'd0);
        MDUCtrl = 4'hF; #1;
        check("undef_result", MDUResult, 32'd0);
        cyc();
        check("undef_hi", HI, 32'd2);
        check("undef_lo", LO, 32'hDEADBEEF);
        MDUCtrl = 4'd0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
